ipf_lcu_feeder: RTL and testbench
=================================

# ipf_lcu_feeder

Input-side transmitter for the IPF filter. Walks a row-major frame memory in LCU raster order and fetches the per-LCU SAO parameter word from a parameter memory. It then streams each pixel, with its LCU coordinates and filter parameters, into IPF's `in_en`/`din`/`busy` port. It replaces the behavioural stimulus driver and sits between the frame/parameter SRAMs and `IPF`.

## Interface
- `IMG_W`, 128, frame width in pixels.
- `IMG_H`, 128, frame height in pixels.
- `LCU`, 16, LCU edge in pixels. Must be 16, 32 or 64 and divide `IMG_W` and `IMG_H`.
- `XW`, `$clog2(IMG_W/LCU)`, width of `lcu_x`/`lcu_y` (3 at defaults).
- `AW`, `$clog2(IMG_W*IMG_H)`, frame address width (14 at defaults).
- `PW`, `$clog2((IMG_W/LCU)*(IMG_H/LCU))`, parameter address width (6 at defaults).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: start a frame; sampled only in IDLE.
- `busy` in 1: IPF back-pressure.
- `img_rd` out 1: frame memory read strobe.
- `img_addr` out AW: frame read address.
- `img_q` in 8: read data, valid the cycle after `img_rd`.
- `par_rd` out 1: parameter memory read strobe; always equal to `img_rd`.
- `par_addr` out PW: LCU index `lcu_y*(IMG_W/LCU)+lcu_x`.
- `par_q` in 24: parameter word, valid the cycle after `par_rd`.
- `in_en` out 1: pixel valid to IPF.
- `din` out 8: pixel.
- `ipf_type` out 2: `par_q[23:22]`.
- `ipf_band_pos` out 5: `par_q[21:17]`.
- `ipf_wo_class` out 1: `par_q[16]`.
- `ipf_offset` out 16: `par_q[15:0]`.
- `lcu_x` out XW: LCU column of the presented pixel.
- `lcu_y` out XW: LCU row of the presented pixel.
- `lcu_size` out 2: constant; 0/1/2 for LCU 16/32/64.
- `active` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle end-of-frame pulse.

## Operation
- FSM states and transitions:
  - IDLE→RUN on `start`.
  - RUN→DRAIN once the last read is issued.
  - DRAIN→IDLE once the last pixel is transferred.
  - `start` is ignored outside IDLE.
- Scan order uses counters `x`, `y` in [0, LCU) and `bx`, `by` in [0, IMG_W/LCU):
  - `x` is innermost, then `y`, then `bx`, then `by`.
  - `img_addr = (by*LCU+y)*IMG_W + bx*LCU + x`.
  - `par_addr = by*(IMG_W/LCU)+bx`.
- Each read captures `{img_q, par_q, bx, by}` one cycle later into a 2-entry FIFO. FIFO head drives `din`, the `ipf_*` outputs, `lcu_x` and `lcu_y`.
- `in_en` = FIFO not empty.
- Transfer: a rising edge with `in_en`=1 and `busy`=0 pops the head.
- Read issue (RUN only): `img_rd` = (count + inflight − pop) < 2. `inflight` is 1 if a read was issued last cycle; `pop` = `in_en && !busy`. This gives a combinational `busy`→`img_rd` path, which is allowed and required for 1 pixel/cycle.
- While `busy`=1 with `in_en`=1, every output to IPF holds stable.
- Parameter fields change exactly on the first pixel of each new LCU.
- `done` is registered at the edge of the final transfer and is high for exactly one cycle. The FSM returns to IDLE on that same edge.
- Reset (`reset`=0 at an edge):
  - All outputs go to 0, including `in_en`, `img_rd`, `par_rd`, `done`, `active`. `lcu_size` is the only exception and stays at its constant.
  - FIFO is emptied, counters cleared, state goes to IDLE.
  - Mid-frame reset abandons the frame with no `done`, and in-flight read data is discarded.

## Timing
- `start` sampled at edge E0 → `img_rd`=1 during cycle E0–E1 at `img_addr` 0 → head loaded at E1 → `in_en`=1 from E1.
- First transfer at E2 if `busy`=0.
- With `busy` held 0: one transfer per edge, E2 through E(N+1), where N = `IMG_W*IMG_H` (16384 at defaults). `done`=1 during E(N+1)–E(N+2).
- No pixel is dropped or duplicated under any `busy` pattern. FIFO never overflows.
- `busy` asserted at the final transfer edge delays `done` by the same number of cycles.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random `start`/`busy` → all outputs 0, `lcu_size`=0, no read strobes.
- Full frame, `busy`=0, frame memory holding `addr[7:0]`, `par_q` = LCU index:
  - Transfer #0 has `din`=0x00; #16 has `din`=0x80 (addr 128).
  - #256 has `din`=0x10, `lcu_x`=1; #2048 has addr 2048, `lcu_y`=1, `lcu_x`=0.
  - Exactly 16384 transfers; `done` at E16385.
- Back-pressure: `busy` pseudo-random at ~75% high → transfer sequence identical to the previous case; `din`/`ipf_*`/`lcu_*` stable throughout every stalled cycle; a single `done`.
- Parameter alignment: `par_q` = `{idx[1:0], idx[4:0], idx[0], 10'h0, idx}` → every transfer's fields match its LCU; fields change only at transfers 256·k.
- Reset mid-frame: `reset`=0 after transfer #1000 → outputs 0 at the next edge, no `done`. A fresh `start` then restarts with `din`=0x00.
- `start` pulsed in RUN and DRAIN → ignored, still 16384 transfers and one `done`. `start` held high through `done` → a second frame begins at addr 0.

Source files
------------

// File: rtl/ipf_lcu_feeder.sv
// Streams a row-major frame to IPF in LCU raster order, one pixel per cycle,
// pairing each pixel with its LCU coordinates and SAO parameter word.
module ipf_lcu_feeder #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int LCU   = 16,
  parameter int XW    = $clog2(IMG_W / LCU),
  parameter int AW    = $clog2(IMG_W * IMG_H),
  parameter int PW    = $clog2((IMG_W / LCU) * (IMG_H / LCU))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          busy,
  output logic          img_rd,
  output logic [AW-1:0] img_addr,
  input  logic [7:0]    img_q,
  output logic          par_rd,
  output logic [PW-1:0] par_addr,
  input  logic [23:0]   par_q,
  output logic          in_en,
  output logic [7:0]    din,
  output logic [1:0]    ipf_type,
  output logic [4:0]    ipf_band_pos,
  output logic          ipf_wo_class,
  output logic [15:0]   ipf_offset,
  output logic [XW-1:0] lcu_x,
  output logic [XW-1:0] lcu_y,
  output logic [1:0]    lcu_size,
  output logic          active,
  output logic          done
);

  localparam int LW  = $clog2(LCU);
  localparam int NBX = IMG_W / LCU;
  localparam int NBY = IMG_H / LCU;
  localparam logic [LW-1:0] LMAX  = LW'(LCU - 1);
  localparam logic [XW-1:0] BXMAX = XW'(NBX - 1);
  localparam logic [XW-1:0] BYMAX = XW'(NBY - 1);
  localparam logic [1:0]    LSZ   = (LCU == 64) ? 2'd2 : ((LCU == 32) ? 2'd1 : 2'd0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] x_q, x_d, y_q, y_d;
  logic [XW-1:0] bx_q, bx_d, by_q, by_d;
  logic          pend_q;
  logic [XW-1:0] pend_bx_q, pend_by_q;
  logic [7:0]    f_pix_q [2];
  logic [23:0]   f_par_q [2];
  logic [XW-1:0] f_bx_q  [2];
  logic [XW-1:0] f_by_q  [2];
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          done_q, done_d;

  logic          in_en_s, pop_s, rd_s, wr_s, pop_st_s, last_pos_s, last_pix_s;
  logic [2:0]    occ_s;
  logic [7:0]    head_pix_s;
  logic [23:0]   head_par_s;
  logic [XW-1:0] head_bx_s, head_by_s;

  // A read issued last cycle (pend_q) is a FIFO entry whose data is still on
  // img_q/par_q; it is presented directly so the first pixel costs no bubble.
  always_comb begin
    in_en_s    = (cnt_q != 2'd0) || pend_q;
    pop_s      = in_en_s && !busy;
    occ_s      = 3'(cnt_q) + 3'(pend_q) - 3'(pop_s);
    rd_s       = (state_q == S_RUN) && (occ_s < 3'd2);
    wr_s       = pend_q && !(pop_s && (cnt_q == 2'd0));
    pop_st_s   = pop_s && (cnt_q != 2'd0);
    last_pix_s = (3'(cnt_q) + 3'(pend_q)) == 3'd1;
    last_pos_s = (x_q == LMAX) && (y_q == LMAX) && (bx_q == BXMAX) && (by_q == BYMAX);
    cnt_d      = cnt_q + 2'(wr_s) - 2'(pop_st_s);
    if (cnt_q != 2'd0) begin
      head_pix_s = f_pix_q[rd_ptr_q];
      head_par_s = f_par_q[rd_ptr_q];
      head_bx_s  = f_bx_q[rd_ptr_q];
      head_by_s  = f_by_q[rd_ptr_q];
    end else if (pend_q) begin
      head_pix_s = img_q;
      head_par_s = par_q;
      head_bx_s  = pend_bx_q;
      head_by_s  = pend_by_q;
    end else begin
      head_pix_s = 8'd0;
      head_par_s = 24'd0;
      head_bx_s  = '0;
      head_by_s  = '0;
    end
  end

  // Scan counters: x innermost, then y, then bx, then by.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    bx_d = bx_q;
    by_d = by_q;
    if (rd_s) begin
      if (x_q == LMAX) begin
        x_d = '0;
        if (y_q == LMAX) begin
          y_d = '0;
          if (bx_q == BXMAX) begin
            bx_d = '0;
            if (by_q == BYMAX) begin
              by_d = '0;
            end else begin
              by_d = by_q + XW'(1);
            end
          end else begin
            bx_d = bx_q + XW'(1);
          end
        end else begin
          y_d = y_q + LW'(1);
        end
      end else begin
        x_d = x_q + LW'(1);
      end
    end else begin
      x_d = x_q;
    end
  end

  // Frame sequencing and end-of-frame pulse.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN: begin
        if (rd_s && last_pos_s) state_d = S_DRAIN;
        else                    state_d = S_RUN;
      end
      S_DRAIN: begin
        if (pop_s && last_pix_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and FIFO storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      pend_q     <= 1'b0;
      pend_bx_q  <= '0;
      pend_by_q  <= '0;
      f_pix_q[0] <= 8'd0;
      f_pix_q[1] <= 8'd0;
      f_par_q[0] <= 24'd0;
      f_par_q[1] <= 24'd0;
      f_bx_q[0]  <= '0;
      f_bx_q[1]  <= '0;
      f_by_q[0]  <= '0;
      f_by_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      pend_q  <= rd_s;
      if (rd_s) begin
        pend_bx_q <= bx_q;
        pend_by_q <= by_q;
      end
      if (wr_s) begin
        f_pix_q[wr_ptr_q] <= img_q;
        f_par_q[wr_ptr_q] <= par_q;
        f_bx_q[wr_ptr_q]  <= pend_bx_q;
        f_by_q[wr_ptr_q]  <= pend_by_q;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_st_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign img_rd       = rd_s;
  assign par_rd       = rd_s;
  assign img_addr     = AW'(by_q) * AW'(LCU * IMG_W) + AW'(y_q) * AW'(IMG_W)
                      + AW'(bx_q) * AW'(LCU) + AW'(x_q);
  assign par_addr     = PW'(by_q) * PW'(NBX) + PW'(bx_q);
  assign in_en        = in_en_s;
  assign din          = head_pix_s;
  assign ipf_type     = head_par_s[23:22];
  assign ipf_band_pos = head_par_s[21:17];
  assign ipf_wo_class = head_par_s[16];
  assign ipf_offset   = head_par_s[15:0];
  assign lcu_x        = head_bx_s;
  assign lcu_y        = head_by_s;
  assign lcu_size     = LSZ;
  assign active       = (state_q != S_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Scoreboard bench for ipf_lcu_feeder at default geometry (128x128, LCU 16).
module tb_ipf_lcu_feeder;
  localparam int N = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy = 1'b0;
  logic [7:0]  img_q = 8'd0;
  logic [23:0] par_q = 24'd0;
  logic        img_rd, par_rd, in_en, ipf_wo_class, active, done;
  logic [13:0] img_addr;
  logic [5:0]  par_addr;
  logic [7:0]  din;
  logic [1:0]  ipf_type, lcu_size;
  logic [4:0]  ipf_band_pos;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x, lcu_y;

  ipf_lcu_feeder dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .img_rd(img_rd), .img_addr(img_addr), .img_q(img_q),
    .par_rd(par_rd), .par_addr(par_addr), .par_q(par_q),
    .in_en(in_en), .din(din), .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos),
    .ipf_wo_class(ipf_wo_class), .ipf_offset(ipf_offset),
    .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
    .active(active), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  din;
    logic [23:0] par;
    logic [2:0]  lx;
    logic [2:0]  ly;
    logic        last;
    logic [15:0] k;
  } exp_t;

  exp_t q[$];
  int   vec = 0;
  int   errs = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   busy_mode = 2;

  function automatic logic [23:0] parfn(input logic [5:0] idx);
    return {idx[1:0], idx[4:0], idx[0], 10'h000, idx};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    int   addr;
    int   k;
    k = 0;
    for (int by = 0; by < 8; by++)
      for (int bx = 0; bx < 8; bx++)
        for (int y = 0; y < 16; y++)
          for (int x = 0; x < 16; x++) begin
            addr   = (by * 16 + y) * 128 + bx * 16 + x;
            e.din  = 8'(addr);
            e.par  = parfn(6'(by * 8 + bx));
            e.lx   = 3'(bx);
            e.ly   = 3'(by);
            e.last = (k == N - 1);
            e.k    = 16'(k);
            q.push_back(e);
            k++;
          end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Synchronous frame/parameter SRAM models.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (img_rd) begin
      img_q <= img_addr[7:0];
      par_q <= parfn(par_addr);
    end
  end

  // Back-pressure: random on the first 4000 and the last 4 pixels of a frame.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (busy_mode == 2)
        busy = 1'($urandom_range(0, 1));
      else if (busy_mode == 1 && (q.size() > N - 4000 || q.size() <= 4))
        busy = ($urandom_range(0, 3) != 0);
      else
        busy = 1'b0;
    end
  end

  // Monitor: a transfer happens at the next rising edge when in_en && !busy.
  initial begin
    logic        prev_stall;
    logic        last_pend;
    logic [38:0] snap, prev_snap;
    logic [23:0] par_out, prev_par;
    logic        ch, ex;
    exp_t        e;
    prev_stall = 1'b0;
    last_pend  = 1'b0;
    prev_snap  = '0;
    prev_par   = '0;
    forever begin
      @(negedge clk);
      par_out = {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset};
      snap    = {in_en, din, par_out, lcu_x, lcu_y};
      if (!reset) begin
        prev_stall = 1'b0;
        last_pend  = 1'b0;
      end else begin
        if (prev_stall) chk("stall_hold", 64'(snap), 64'(prev_snap));
        if (done || last_pend) chk("done_pulse", 64'(done), 64'(last_pend));
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        last_pend = 1'b0;
        if (img_rd || par_rd) chk("par_rd_eq", 64'(par_rd), 64'(img_rd));
        if (in_en && !busy) begin
          if (q.size() == 0) begin
            vec++;
            errs++;
            $display("FAIL extra_xfer: got din 0x%0h, expected no transfer", din);
          end else begin
            e = q.pop_front();
            chk("xfer", 64'({din, par_out, lcu_x, lcu_y}), 64'({e.din, e.par, e.lx, e.ly}));
            if (e.k == 16'd0)    chk("xfer0_din", 64'(din), 64'h00);
            if (e.k == 16'd16)   chk("xfer16_din", 64'(din), 64'h80);
            if (e.k == 16'd256)  chk("xfer256", 64'({din, lcu_y, lcu_x}), 64'({8'h10, 3'd0, 3'd1}));
            if (e.k == 16'd2048) chk("xfer2048", 64'({din, lcu_y, lcu_x}), 64'({8'h00, 3'd1, 3'd0}));
            if (e.k != 16'd0) begin
              ch = (par_out != prev_par);
              ex = (e.k[7:0] == 8'd0);
              if (ch || ex) chk("par_change", 64'(ch), 64'(ex));
            end
            prev_par  = par_out;
            last_pend = e.last;
          end
        end
        prev_stall = in_en && busy;
        prev_snap  = snap;
      end
    end
  end

  // Stimulus.
  initial begin
    int c0;
    int dc;
    // Reset held with random start/busy.
    repeat (2) begin
      @(posedge clk);
      #1;
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_outs", 64'({img_rd, img_addr, par_rd, par_addr, in_en, din, ipf_type, ipf_band_pos,
                           ipf_wo_class, ipf_offset, lcu_x, lcu_y, active, done}), 64'd0);
      chk("rst_size", 64'(lcu_size), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    busy_mode = 0;

    // Frame A: busy low, start pulsed in RUN and DRAIN.
    @(posedge clk);
    #1;
    push_frame();
    dc = done_cnt;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_cyc(c0 + 100);
    start = 1'b1;
    wait_cyc(c0 + 101);
    start = 1'b0;
    wait_cyc(c0 + 16385);
    chk("drain_state", 64'({active, img_rd}), 64'({1'b1, 1'b0}));
    start = 1'b1;
    wait_cyc(c0 + 16386);
    start = 1'b0;
    wait_cyc(c0 + 16392);
    chk("frameA_done_cnt", 64'(done_cnt - dc), 64'd1);
    chk("frameA_done_time", 64'(done_cyc - c0 - 1), 64'd16385);
    chk("frameA_q_empty", 64'(q.size()), 64'd0);
    chk("frameA_idle", 64'(active), 64'd0);

    // Mid-frame reset after transfer #1000.
    push_frame();
    dc = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && q.size() > N - 1001; i++) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_reached", 64'(q.size() <= N - 1001), 64'd1);
    reset = 1'b0;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outs", 64'({img_rd, img_addr, par_rd, par_addr, in_en, din, ipf_type, ipf_band_pos,
                            ipf_wo_class, ipf_offset, lcu_x, lcu_y, active, done}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt - dc), 64'd0);

    // Frame B: back-pressure, start held high through done.
    push_frame();
    dc = done_cnt;
    busy_mode = 1;
    start = 1'b1;
    for (int i = 0; i < 40000 && done_cnt == dc; i++) @(negedge clk);
    chk("frameB_done_cnt", 64'(done_cnt - dc), 64'd1);
    chk("frameB_q_empty", 64'(q.size()), 64'd0);
    busy_mode = 0;
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b0;

    // Frame C: begins from address 0 because start was still high.
    for (int i = 0; i < 200 && q.size() > N - 21; i++) begin
      @(posedge clk);
      #1;
    end
    chk("frameC_started", 64'(q.size() <= N - 21), 64'd1);
    reset = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
